rdmx_xmit_arb: RTL and testbench
================================

// Module: rdmx_xmit_arb
//
// PURPOSE
//  Packet-atomic round-robin arbiter sharing one RDMX transmit back-end between two
//  transmit front-ends. Each front-end supplies a stream triplet: packet-length, target
//  address and packet data. Arbitration is per packet. The arbiter forwards the granted
//  source's header (PLEN+ADDR), then its data beats through TLAST, and only then re-arbitrates.
//
// PARAMETERS
//  DATA_WBITS  512  width of packet-data TDATA, bits
//  ADDR_WBITS   64  width of target-address TDATA, bits
//
// PORTS  (n = 0,1; per-channel rows list TDATA/TVALID/TREADY)
//  clk                          in   1            clock
//  resetn                       in   1            async reset, active-low
//  AXIS_IN<n>_PLEN_*            in/in/out  16/1/1          source n packet length, bytes
//  AXIS_IN<n>_ADDR_*            in/in/out  ADDR_WBITS/1/1  source n target address
//  AXIS_IN<n>_DATA_*            in/in/out  DATA_WBITS/1/1  source n packet data
//  AXIS_IN<n>_DATA_TLAST        in   1            source n last data beat
//  AXIS_OUT_PLEN_*              out/out/in 16/1/1          shared packet length
//  AXIS_OUT_ADDR_*              out/out/in ADDR_WBITS/1/1  shared target address
//  AXIS_OUT_DATA_*              out/out/in DATA_WBITS/1/1  shared packet data
//  AXIS_OUT_DATA_TLAST          out  1            shared last data beat
//  grant                        out  1            source currently owning the back-end
//  busy                         out  1            1 in HDR or DATA state
//  pkt_count0, pkt_count1       out  32           packets completed per source
//
// BEHAVIOUR
//  Reset is asynchronous, active-low. All registers clear immediately: state=IDLE,
//   grant=0, last_grant=1 (source 0 wins first), hdr flags=0, counters=0. All TVALID
//   and TREADY outputs are 0 while resetn=0. A packet in flight is abandoned with no
//   recovery; upstream and downstream FIFOs are reset with the block.
//  Eligible(n) = IN<n>_PLEN_TVALID & IN<n>_ADDR_TVALID. Data valid alone never makes
//   a source eligible.
//  State machine:
//   IDLE: if exactly one source is eligible, register grant=n. If both are eligible,
//    grant=~last_grant. Go to HDR on the next edge. This costs one arbitration bubble.
//    If neither is eligible, stay in IDLE.
//   HDR: OUT_PLEN = IN<grant>_PLEN and OUT_ADDR = IN<grant>_ADDR, passed through
//    combinationally. Each stream has a done flag (plen_done, addr_done).
//    OUT_x_TVALID = IN<grant>_x_TVALID & ~x_done.
//    IN<grant>_x_TREADY = OUT_x_TREADY & ~x_done.
//    A flag sets on its handshake. The two streams complete independently, in either
//    order or in the same cycle. When both are done (counting this cycle's handshakes),
//    clear the flags and go to DATA.
//   DATA: OUT_DATA TDATA/TLAST/TVALID = IN<grant>_DATA.
//    IN<grant>_DATA_TREADY = OUT_DATA_TREADY. On a handshake with TLAST=1:
//    pkt_count<grant>++ (wraps at 2^32), last_grant<=grant, go to IDLE.
//  Non-granted source: all TREADY=0. Every input TREADY=0 in IDLE. Data TREADY=0 in HDR.
//  Outputs of non-active streams: TVALID=0. TDATA is don't-care but driven from
//   IN<grant> (no extra mux term).
//  No combinational path from any OUT TREADY to any OUT TVALID.
//  The PLEN value is not checked against the data beats. A zero-data packet is
//   illegal; every packet carries at least one beat.
//  Throughput: one data beat per cycle in DATA. Packet-to-packet overhead is 1 IDLE
//   cycle plus at least 1 HDR cycle.
//
// TESTING
//  1 Reset: resetn=0 with all inputs valid -> all TVALID/TREADY=0, counts=0, grant=0.
//  2 Single source: src0 sends PLEN=128, ADDR=0x1000, 2 beats -> OUT carries the same
//    values. HDR is entered 1 cycle after eligible. pkt_count0=1. src1 is never readied.
//  3 Contention: both sources eligible continuously, 4 packets each -> grant sequence
//    0,1,0,1,...; no interleaving of beats between packets; counts 4/4.
//  4 Header split: OUT_ADDR_TREADY held 0 for 5 cycles while OUT_PLEN_TREADY=1 ->
//    PLEN is taken once (no duplicate), ADDR follows, then DATA; PLEN is not re-presented.
//  5 Backpressure: OUT_DATA_TREADY toggling 1010 over an 8-beat packet -> 8 beats in
//    order, TLAST only on beat 8, no drops or duplicates.
//  6 Mid-packet reset: resetn=0 asynchronously after beat 3 of 6 -> outputs go to 0
//    before the next edge. After release, state is IDLE, source 0 has priority, and
//    counts=0.

Source files
------------

// File: rtl/rdmx_xmit_arb_if.sv
// Stream triplet carried between an RDMX transmit front-end and back-end:
// packet length, target address and packet data, each with its own handshake.
interface rdmx_xmit_arb_if #(
  parameter int DATA_WBITS = 512,
  parameter int ADDR_WBITS = 64
);
  logic [15:0]           plen_tdata;
  logic                  plen_tvalid;
  logic                  plen_tready;

  logic [ADDR_WBITS-1:0] addr_tdata;
  logic                  addr_tvalid;
  logic                  addr_tready;

  logic [DATA_WBITS-1:0] data_tdata;
  logic                  data_tlast;
  logic                  data_tvalid;
  logic                  data_tready;

  // Producer side of the triplet
  modport master (
    output plen_tdata, plen_tvalid,
    input  plen_tready,
    output addr_tdata, addr_tvalid,
    input  addr_tready,
    output data_tdata, data_tlast, data_tvalid,
    input  data_tready
  );

  // Consumer side of the triplet
  modport slave (
    input  plen_tdata, plen_tvalid,
    output plen_tready,
    input  addr_tdata, addr_tvalid,
    output addr_tready,
    input  data_tdata, data_tlast, data_tvalid,
    output data_tready
  );
endinterface

// File: rtl/rdmx_xmit_arb.sv
// Packet-atomic round-robin arbiter sharing one RDMX transmit back-end between
// two front-ends. A granted source keeps the back-end from its header through
// its TLAST beat; arbitration only happens in IDLE.
module rdmx_xmit_arb #(
  parameter int DATA_WBITS = 512,
  parameter int ADDR_WBITS = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  rdmx_xmit_arb_if.slave         axis_in0,
  rdmx_xmit_arb_if.slave         axis_in1,
  rdmx_xmit_arb_if.master        axis_out,
  output logic                   grant,
  output logic                   busy,
  output logic [31:0]            pkt_count0,
  output logic [31:0]            pkt_count1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  plen_done_q, plen_done_d;
  logic                  addr_done_q, addr_done_d;
  logic [31:0]           pkt_count0_q, pkt_count0_d;
  logic [31:0]           pkt_count1_q, pkt_count1_d;

  logic [15:0]           sel_plen_tdata;
  logic                  sel_plen_tvalid;
  logic [ADDR_WBITS-1:0] sel_addr_tdata;
  logic                  sel_addr_tvalid;
  logic [DATA_WBITS-1:0] sel_data_tdata;
  logic                  sel_data_tlast;
  logic                  sel_data_tvalid;

  logic                  out_plen_tvalid, out_addr_tvalid, out_data_tvalid;
  logic                  sel_plen_tready, sel_addr_tready, sel_data_tready;
  logic                  plen_hs, addr_hs, data_hs;
  logic                  elig0, elig1;

  // Only a complete header (length and address both valid) makes a source eligible
  assign elig0 = axis_in0.plen_tvalid & axis_in0.addr_tvalid;
  assign elig1 = axis_in1.plen_tvalid & axis_in1.addr_tvalid;

  // Select the granted source's streams; data always follows grant, even when idle
  always_comb begin
    if (grant_q) begin
      sel_plen_tdata  = axis_in1.plen_tdata;
      sel_plen_tvalid = axis_in1.plen_tvalid;
      sel_addr_tdata  = axis_in1.addr_tdata;
      sel_addr_tvalid = axis_in1.addr_tvalid;
      sel_data_tdata  = axis_in1.data_tdata;
      sel_data_tlast  = axis_in1.data_tlast;
      sel_data_tvalid = axis_in1.data_tvalid;
    end else begin
      sel_plen_tdata  = axis_in0.plen_tdata;
      sel_plen_tvalid = axis_in0.plen_tvalid;
      sel_addr_tdata  = axis_in0.addr_tdata;
      sel_addr_tvalid = axis_in0.addr_tvalid;
      sel_data_tdata  = axis_in0.data_tdata;
      sel_data_tlast  = axis_in0.data_tlast;
      sel_data_tvalid = axis_in0.data_tvalid;
    end
  end

  // Gate valids and readies by state; valids depend only on registered state, never on out readies
  always_comb begin
    out_plen_tvalid = 1'b0;
    out_addr_tvalid = 1'b0;
    out_data_tvalid = 1'b0;
    sel_plen_tready = 1'b0;
    sel_addr_tready = 1'b0;
    sel_data_tready = 1'b0;
    case (state_q)
      HDR: begin
        out_plen_tvalid = sel_plen_tvalid & ~plen_done_q;
        out_addr_tvalid = sel_addr_tvalid & ~addr_done_q;
        sel_plen_tready = axis_out.plen_tready & ~plen_done_q;
        sel_addr_tready = axis_out.addr_tready & ~addr_done_q;
      end
      DATA: begin
        out_data_tvalid = sel_data_tvalid;
        sel_data_tready = axis_out.data_tready;
      end
      default: begin
      end
    endcase
  end

  assign plen_hs = out_plen_tvalid & axis_out.plen_tready;
  assign addr_hs = out_addr_tvalid & axis_out.addr_tready;
  assign data_hs = out_data_tvalid & axis_out.data_tready;

  assign axis_out.plen_tdata  = sel_plen_tdata;
  assign axis_out.plen_tvalid = out_plen_tvalid;
  assign axis_out.addr_tdata  = sel_addr_tdata;
  assign axis_out.addr_tvalid = out_addr_tvalid;
  assign axis_out.data_tdata  = sel_data_tdata;
  assign axis_out.data_tlast  = sel_data_tlast;
  assign axis_out.data_tvalid = out_data_tvalid;

  assign axis_in0.plen_tready = sel_plen_tready & ~grant_q;
  assign axis_in0.addr_tready = sel_addr_tready & ~grant_q;
  assign axis_in0.data_tready = sel_data_tready & ~grant_q;
  assign axis_in1.plen_tready = sel_plen_tready & grant_q;
  assign axis_in1.addr_tready = sel_addr_tready & grant_q;
  assign axis_in1.data_tready = sel_data_tready & grant_q;

  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;

  // Arbitrate in IDLE, track header completion in HDR, count packets on TLAST in DATA
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    plen_done_d  = plen_done_q;
    addr_done_d  = addr_done_q;
    pkt_count0_d = pkt_count0_q;
    pkt_count1_d = pkt_count1_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          state_d = HDR;
          if (elig0 & elig1) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = elig1;
          end
        end
      end
      HDR: begin
        plen_done_d = plen_done_q | plen_hs;
        addr_done_d = addr_done_q | addr_hs;
        if (plen_done_d & addr_done_d) begin
          plen_done_d = 1'b0;
          addr_done_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (data_hs & sel_data_tlast) begin
          if (grant_q) begin
            pkt_count1_d = pkt_count1_q + 32'd1;
          end else begin
            pkt_count0_d = pkt_count0_q + 32'd1;
          end
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight and gives source 0 first turn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      plen_done_q  <= 1'b0;
      addr_done_q  <= 1'b0;
      pkt_count0_q <= 32'd0;
      pkt_count1_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      plen_done_q  <= plen_done_d;
      addr_done_q  <= addr_done_d;
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
    end
  end

endmodule

// File: tb/tb_rdmx_xmit_arb.sv
// Self-checking bench for rdmx_xmit_arb: two packet-source drivers, a
// back-end sink with controllable readies, and a scoreboard of expected
// headers, beats and grant order.
module tb_rdmx_xmit_arb;
  localparam int DW = 512;
  localparam int AW = 64;

  typedef struct {
    logic [15:0] plen;
    logic [63:0] addr;
    int          nbeats;
    int          tag;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        grant, busy;
  logic [31:0] pkt_count0, pkt_count1;

  logic        out_plen_r = 1'b1;
  logic        out_addr_r = 1'b1;
  logic        tog = 1'b1;
  logic        toggle_mode = 1'b0;
  logic        flood = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int plen_hs_cnt = 0;
  int beats_seen = 0;

  req_t        req_q[2][$];
  logic [15:0] exp_plen_q[2][$];
  logic [63:0] exp_addr_q[2][$];
  logic [DW:0] exp_beat_q[2][$];
  int          exp_grant_q[$];

  always #5 clk = ~clk;

  rdmx_xmit_arb_if #(.DATA_WBITS(DW), .ADDR_WBITS(AW)) in0_if ();
  rdmx_xmit_arb_if #(.DATA_WBITS(DW), .ADDR_WBITS(AW)) in1_if ();
  rdmx_xmit_arb_if #(.DATA_WBITS(DW), .ADDR_WBITS(AW)) out_if ();

  rdmx_xmit_arb #(.DATA_WBITS(DW), .ADDR_WBITS(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .axis_in0   (in0_if),
    .axis_in1   (in1_if),
    .axis_out   (out_if),
    .grant      (grant),
    .busy       (busy),
    .pkt_count0 (pkt_count0),
    .pkt_count1 (pkt_count1)
  );

  assign out_if.plen_tready = out_plen_r;
  assign out_if.addr_tready = out_addr_r;
  assign out_if.data_tready = tog;

  function automatic logic [DW-1:0] beat_word(input int tag, input int b);
    logic [31:0] w;
    w = {tag[15:0], b[15:0]};
    return {16{w}};
  endfunction

  task automatic push_req(input int src, input logic [15:0] plen, input logic [63:0] addr,
                          input int nbeats, input int tag);
    req_t r;
    r.plen = plen; r.addr = addr; r.nbeats = nbeats; r.tag = tag;
    req_q[src].push_back(r);
  endtask

  // Data-ready pattern for the sink: steady 1, or alternating 1,0,1,0 per cycle
  initial begin
    forever begin
      @(posedge clk); #1;
      tog = toggle_mode ? ~tog : 1'b1;
    end
  end

  // One packet driver per source; drives at posedge+1, samples handshakes at negedge
  for (genvar g = 0; g < 2; g++) begin : g_drv
    logic [15:0]   plen;
    logic          plen_v;
    logic [63:0]   addr;
    logic          addr_v;
    logic [DW-1:0] data;
    logic          last;
    logic          data_v;
    logic          plen_r, addr_r, data_r;

    assign plen_r = (g == 0) ? in0_if.plen_tready : in1_if.plen_tready;
    assign addr_r = (g == 0) ? in0_if.addr_tready : in1_if.addr_tready;
    assign data_r = (g == 0) ? in0_if.data_tready : in1_if.data_tready;

    initial begin
      req_t p;
      logic p_hs, a_hs, d_hs, ab;
      int   beat;
      plen = '0; plen_v = 1'b0; addr = '0; addr_v = 1'b0;
      data = '0; last = 1'b0; data_v = 1'b0;
      forever begin
        @(posedge clk); #1;
        while (resetn && req_q[g].size() > 0) begin
          p = req_q[g].pop_front();
          exp_plen_q[g].push_back(p.plen);
          exp_addr_q[g].push_back(p.addr);
          for (int b = 0; b < p.nbeats; b++)
            exp_beat_q[g].push_back({(b == p.nbeats - 1), beat_word(p.tag, b)});
          plen = p.plen; plen_v = 1'b1;
          addr = p.addr; addr_v = 1'b1;
          beat = 0;
          data = beat_word(p.tag, 0); last = (p.nbeats == 1); data_v = 1'b1;
          ab = 1'b0;
          while (beat < p.nbeats) begin
            @(negedge clk);
            if (!resetn) begin
              ab = 1'b1;
              break;
            end
            p_hs = plen_v & plen_r;
            a_hs = addr_v & addr_r;
            d_hs = data_v & data_r;
            @(posedge clk); #1;
            if (p_hs) plen_v = 1'b0;
            if (a_hs) addr_v = 1'b0;
            if (d_hs) begin
              beat++;
              if (beat < p.nbeats) begin
                data = beat_word(p.tag, beat);
                last = (beat == p.nbeats - 1);
              end else begin
                data_v = 1'b0;
              end
            end
          end
          if (ab) begin
            plen_v = 1'b0; addr_v = 1'b0; data_v = 1'b0;
          end
        end
      end
    end
  end

  assign in0_if.plen_tdata  = g_drv[0].plen;
  assign in0_if.plen_tvalid = g_drv[0].plen_v | flood;
  assign in0_if.addr_tdata  = g_drv[0].addr;
  assign in0_if.addr_tvalid = g_drv[0].addr_v | flood;
  assign in0_if.data_tdata  = g_drv[0].data;
  assign in0_if.data_tlast  = g_drv[0].last | flood;
  assign in0_if.data_tvalid = g_drv[0].data_v | flood;
  assign in1_if.plen_tdata  = g_drv[1].plen;
  assign in1_if.plen_tvalid = g_drv[1].plen_v | flood;
  assign in1_if.addr_tdata  = g_drv[1].addr;
  assign in1_if.addr_tvalid = g_drv[1].addr_v | flood;
  assign in1_if.data_tdata  = g_drv[1].data;
  assign in1_if.data_tlast  = g_drv[1].last | flood;
  assign in1_if.data_tvalid = g_drv[1].data_v | flood;

  // Scoreboard: every back-end handshake is checked against what the granted source sent
  initial begin
    int          gi, eg;
    logic [15:0] ep;
    logic [63:0] ea;
    logic [DW:0] eb;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        gi = (grant === 1'b1) ? 1 : 0;
        vectors++;
        if ((gi == 0 && (in1_if.plen_tready | in1_if.addr_tready | in1_if.data_tready) !== 1'b0) ||
            (gi == 1 && (in0_if.plen_tready | in0_if.addr_tready | in0_if.data_tready) !== 1'b0)) begin
          miscompares++;
          $display("[TB] FAIL nongrant_ready: source %0d readied while grant=%0d", 1 - gi, gi);
        end
        if (out_if.plen_tvalid === 1'b1 && out_if.plen_tready === 1'b1) begin
          plen_hs_cnt++;
          vectors++;
          if (exp_grant_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL grant_seq: header from source %0d, no header expected", gi);
          end else begin
            eg = exp_grant_q.pop_front();
            if (gi != eg) begin
              miscompares++;
              $display("[TB] FAIL grant_seq: got %0d expected %0d", gi, eg);
            end
          end
          vectors++;
          if (exp_plen_q[gi].size() == 0) begin
            miscompares++;
            $display("[TB] FAIL plen: got %h, none expected", out_if.plen_tdata);
          end else begin
            ep = exp_plen_q[gi].pop_front();
            if (out_if.plen_tdata !== ep) begin
              miscompares++;
              $display("[TB] FAIL plen: got %h expected %h", out_if.plen_tdata, ep);
            end
          end
        end
        if (out_if.addr_tvalid === 1'b1 && out_if.addr_tready === 1'b1) begin
          vectors++;
          if (exp_addr_q[gi].size() == 0) begin
            miscompares++;
            $display("[TB] FAIL addr: got %h, none expected", out_if.addr_tdata);
          end else begin
            ea = exp_addr_q[gi].pop_front();
            if (out_if.addr_tdata !== ea) begin
              miscompares++;
              $display("[TB] FAIL addr: got %h expected %h", out_if.addr_tdata, ea);
            end
          end
        end
        if (out_if.data_tvalid === 1'b1 && out_if.data_tready === 1'b1) begin
          beats_seen++;
          vectors++;
          if (exp_beat_q[gi].size() == 0) begin
            miscompares++;
            $display("[TB] FAIL beat: got last=%b data[31:0]=%h, none expected",
                     out_if.data_tlast, out_if.data_tdata[31:0]);
          end else begin
            eb = exp_beat_q[gi].pop_front();
            if ({out_if.data_tlast, out_if.data_tdata} !== eb) begin
              miscompares++;
              $display("[TB] FAIL beat: got last=%b data[31:0]=%h expected last=%b data[31:0]=%h",
                       out_if.data_tlast, out_if.data_tdata[31:0], eb[DW], eb[31:0]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 flood = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_if.plen_tvalid, out_if.addr_tvalid, out_if.data_tvalid} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 000",
               {out_if.plen_tvalid, out_if.addr_tvalid, out_if.data_tvalid});
    end
    vectors++;
    if ({in0_if.plen_tready, in0_if.addr_tready, in0_if.data_tready,
         in1_if.plen_tready, in1_if.addr_tready, in1_if.data_tready} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 000000",
               {in0_if.plen_tready, in0_if.addr_tready, in0_if.data_tready,
                in1_if.plen_tready, in1_if.addr_tready, in1_if.data_tready});
    end
    vectors++;
    if ({pkt_count0, pkt_count1} !== 64'd0 || grant !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got counts %0d/%0d grant %b busy %b expected 0/0 0 0",
               pkt_count0, pkt_count1, grant, busy);
    end
    flood = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single;
    logic saw1;
    int   i;
    saw1 = 1'b0;
    @(negedge clk);
    exp_grant_q.push_back(0);
    push_req(0, 16'd128, 64'h1000, 2, 1);
    for (i = 0; i < 20 && g_drv[0].plen_v !== 1'b1; i++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (g_drv[0].plen_v !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got busy %b expected 0 in eligible cycle", busy);
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b1 || out_if.plen_tvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_hdr_latency: got busy %b plen_valid %b expected 1 1",
               busy, out_if.plen_tvalid);
    end
    for (i = 0; i < 50 && pkt_count0 !== 32'd1; i++) begin
      @(negedge clk);
      if ((in1_if.plen_tready | in1_if.addr_tready | in1_if.data_tready) !== 1'b0) saw1 = 1'b1;
    end
    vectors++;
    if (pkt_count0 !== 32'd1 || pkt_count1 !== 32'd0 || saw1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d/%0d src1_readied %b expected 1/0 0",
               pkt_count0, pkt_count1, saw1);
    end
  endtask

  task automatic test_contention;
    int i;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
      push_req(0, 16'(64 + k), 64'h2000 + 64'(k), 2 + (k % 2), 10 + k);
      push_req(1, 16'(96 + k), 64'h3000 + 64'(k), 3 - (k % 2), 20 + k);
    end
    for (i = 0; i < 400 && !(pkt_count0 === 32'd4 && pkt_count1 === 32'd4); i++) @(negedge clk);
    vectors++;
    if (pkt_count0 !== 32'd4 || pkt_count1 !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL contention_count: got %0d/%0d expected 4/4", pkt_count0, pkt_count1);
    end
    vectors++;
    if (exp_grant_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL contention_headers: got %0d headers missing expected 0", exp_grant_q.size());
    end
  endtask

  task automatic test_header_split;
    int   base, i;
    logic bad;
    bad = 1'b0;
    @(posedge clk); #1;
    out_addr_r = 1'b0;
    @(negedge clk);
    exp_grant_q.push_back(0);
    push_req(0, 16'd64, 64'hABCD_0000, 2, 30);
    base = plen_hs_cnt;
    for (i = 0; i < 30 && plen_hs_cnt != base + 1; i++) begin
      @(negedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (out_if.plen_tvalid !== 1'b0 || out_if.addr_tvalid !== 1'b1 || in0_if.data_tready !== 1'b0)
        bad = 1'b1;
    end
    vectors++;
    if (plen_hs_cnt != base + 1 || bad !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL header_split: got plen handshakes %0d bad %b expected 1 0",
               plen_hs_cnt - base, bad);
    end
    @(posedge clk); #1;
    out_addr_r = 1'b1;
    for (i = 0; i < 50 && pkt_count0 !== 32'd5; i++) @(negedge clk);
    vectors++;
    if (pkt_count0 !== 32'd5 || plen_hs_cnt != base + 1) begin
      miscompares++;
      $display("[TB] FAIL header_split_done: got count %0d plen handshakes %0d expected 5 1",
               pkt_count0, plen_hs_cnt - base);
    end
  endtask

  task automatic test_back_pressure;
    int base, i;
    @(negedge clk);
    exp_grant_q.push_back(0);
    push_req(0, 16'd512, 64'h4000, 8, 40);
    base = beats_seen;
    toggle_mode = 1'b1;
    for (i = 0; i < 200 && pkt_count0 !== 32'd6; i++) @(negedge clk);
    toggle_mode = 1'b0;
    vectors++;
    if (pkt_count0 !== 32'd6 || beats_seen - base != 8) begin
      miscompares++;
      $display("[TB] FAIL backpressure: got count %0d beats %0d expected 6 8",
               pkt_count0, beats_seen - base);
    end
  endtask

  task automatic test_mid_reset;
    int base, i;
    @(negedge clk);
    exp_grant_q.push_back(0);
    push_req(0, 16'd384, 64'h5000, 6, 50);
    base = beats_seen;
    for (i = 0; i < 50 && beats_seen != base + 3; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({out_if.plen_tvalid, out_if.addr_tvalid, out_if.data_tvalid,
         in0_if.data_tready, in1_if.data_tready, busy} !== 6'b0 || beats_seen != base + 3) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b beats %0d expected 000000 3",
               {out_if.plen_tvalid, out_if.addr_tvalid, out_if.data_tvalid,
                in0_if.data_tready, in1_if.data_tready, busy}, beats_seen - base);
    end
    vectors++;
    if (pkt_count0 !== 32'd0 || pkt_count1 !== 32'd0 || grant !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got %0d/%0d grant %b expected 0/0 0",
               pkt_count0, pkt_count1, grant);
    end
    for (int s = 0; s < 2; s++) begin
      exp_plen_q[s].delete();
      exp_addr_q[s].delete();
      exp_beat_q[s].delete();
      req_q[s].delete();
    end
    exp_grant_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || grant !== 1'b0 || pkt_count0 !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_release: got busy %b grant %b count %0d expected 0 0 0",
               busy, grant, pkt_count0);
    end
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    push_req(0, 16'd32, 64'h6000, 1, 60);
    push_req(1, 16'd48, 64'h7000, 1, 61);
    for (i = 0; i < 50 && !(pkt_count0 === 32'd1 && pkt_count1 === 32'd1); i++) @(negedge clk);
    vectors++;
    if (pkt_count0 !== 32'd1 || pkt_count1 !== 32'd1 || exp_grant_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_priority: got %0d/%0d pending headers %0d expected 1/1 0",
               pkt_count0, pkt_count1, exp_grant_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_header_split();
    test_back_pressure();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
